// File: rtl/serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_pkg
//   Shared constants and types for the serial adder controller.
//   - state_e : controller state encoding (IDLE=0, RUN=1, DONE=2; 3 illegal)
//   - SLICE_W : width of the shared adder slice in bits
//   - step_width() : step counter width for a given operand width
// ---------------------------------------------------------------------------
package serial_add_ctrl_pkg;

  localparam int unsigned SLICE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold 0..N-1 with N = width/SLICE_W; never narrower than 1 bit.
  function automatic int unsigned step_width(input int unsigned width);
    int unsigned n;
    n = width / SLICE_W;
    step_width = (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_slice2.sv
// ---------------------------------------------------------------------------
// add_slice2
//   Purely combinational 2-bit adder slice with carry-in.
//   Ports:
//     x[1:0], y[1:0] : addend pair
//     ci             : carry in
//     z[1:0]         : low two bits of zero-extended x + y + ci
//     co             : bit 2 of zero-extended x + y + ci
// ---------------------------------------------------------------------------
module add_slice2
  import serial_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               ci,
  output logic [SLICE_W-1:0] z,
  output logic               co
);

  logic [SLICE_W:0] r;

  // Extend before adding so the carry bit survives.
  always_comb begin
    r = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, ci};
  end

  assign z  = r[SLICE_W-1:0];
  assign co = r[SLICE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Adds two WIDTH-bit operands over WIDTH/2 clock steps using one shared
//   2-bit add_slice2, least-significant pair first, carry held in a register.
//   Ports:
//     clk   : clock, rising edge
//     rst   : asynchronous active-high reset
//     start : request, sampled only in IDLE
//     a, b  : operands, latched on accepted start
//     busy  : high in RUN and DONE
//     done  : one-cycle pulse, result valid
//     sum   : registered result (mod 2^WIDTH)
//     cout  : registered carry out of the MSB slice
// ---------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned N  = WIDTH / SLICE_W;
  localparam int unsigned CW = step_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     step_q, step_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [CW:0]        bit_idx;
  logic [SLICE_W-1:0] sl_x, sl_y, sl_z;
  logic               sl_co;

  // Bit offset of the current slice pair: step * 2.
  assign bit_idx = {step_q, 1'b0};
  assign sl_x    = a_q[bit_idx +: SLICE_W];
  assign sl_y    = b_q[bit_idx +: SLICE_W];

  add_slice2 u_slice (
    .x  (sl_x),
    .y  (sl_y),
    .ci (carry_q),
    .z  (sl_z),
    .co (sl_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      step_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      step_q  <= step_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    step_d  = step_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          step_d  = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        sum_d[bit_idx +: SLICE_W] = sl_z;
        carry_d                   = sl_co;
        if (step_q == LAST_STEP) begin
          // Counter wraps to 0 instead of N so it never leaves 0..N-1.
          step_d  = '0;
          cout_d  = sl_co;
          state_d = ST_DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Multi-cycle controller that adds two WIDTH-bit operands by sequencing one shared 2-bit adder slice, least-significant pair first.
- Carry is held in a register between slice steps.
- Provides a start/busy/done handshake so wide additions can reuse the team's narrow adder datapath instead of a full-width adder.
- Sits between a requesting unit (test driver or datapath sequencer) and the 2-bit slice.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2; number of slice steps N = WIDTH/2.

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only when state is IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result, registered
cout  output  1  carry out of MSB slice, registered

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset, asynchronous, any time including mid-operation:
  - state=IDLE; busy=0, done=0, sum=0, cout=0
  - internal a/b registers, carry register and step counter all cleared
  - any in-flight operation is abandoned with no done pulse.
- States: IDLE, RUN, DONE (2-bit encoding: IDLE=0, RUN=1, DONE=2; encoding 3 is illegal and goes to IDLE).
- IDLE:
  - start=1 at an edge: latch a, b; carry=0; step=0; sum=0; cout=0; go to RUN.
  - start=0: stay in IDLE; sum and cout hold the previous result.
- RUN, each edge, step k (0..N-1):
  - slice inputs x=a_reg[2k+1:2k], y=b_reg[2k+1:2k], ci=carry.
  - 3-bit slice result r = x + y + ci, zero-extended; never truncate before the carry is taken.
  - sum[2k+1:2k] <= r[1:0]; carry <= r[2]; step <= k+1.
  - at k=N-1: cout <= r[2] and go to DONE.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE unconditionally.
- Outputs and latency:
  - busy and done are decoded from the state register (no combinational path from inputs).
  - start accepted at edge E0 -> done high during the cycle after edge E(N) (WIDTH=8: after E4).
  - sum and cout are stable and valid from that cycle until the next accepted start.
- start while busy (RUN or DONE) is ignored and not queued. The earliest next acceptance is edge E(N+2), so the back-to-back period is N+2 cycles.
- a and b may change freely after the accepting edge; only the latched copies are used.
- Wrap-around: a+b >= 2^WIDTH gives sum = (a+b) mod 2^WIDTH with cout=1.
- Step counter width is clog2(N), minimum 1 bit; the counter never exceeds N-1.

Decomposition:
- Shared constants include file: state encodings (ST_IDLE, ST_RUN, ST_DONE) and the slice width constant (2).
- One sub-module, add_slice2: purely combinational 2-bit adder with carry-in. Ports x[1:0], y[1:0], ci, z[1:0], co; z/co = low/high part of the zero-extended x+y+ci.
- serial_add_ctrl instantiates exactly one add_slice2; the FSM, operand registers, counter and result register live in serial_add_ctrl.

Test Plan:
- Reset release, start held 0 for 5 cycles -> busy=0, done=0, sum=0x00, cout=0 throughout.
- WIDTH=8, start with a=0x35, b=0x4A -> busy high from E0; done pulses 1 cycle after E4; sum=0x7F, cout=0; done low again after E5.
- a=0xFF, b=0x01 -> carry ripples through all 4 steps; sum=0x00, cout=1. Separately, a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- Start accepted with a=0x10, b=0x20; start re-asserted with a=0xAA, b=0xAA at E1..E5 -> only the first op completes (sum=0x30); 0xAA+0xAA is accepted at E6 and yields sum=0x54, cout=1.
- Change a, b on the cycle after acceptance -> result still reflects the latched values.
- Assert rst asynchronously mid-RUN (between E2 and E3) -> outputs go to 0 immediately without waiting for a clock; no done pulse. After release, a new start completes normally.
